// File: rtl/corr_collector_pkg.sv
// Shared encodings, widths and saturating helpers for the correlation collector.
// Imported by the top and the toggle detector.
package corr_collector_pkg;

    localparam int NUM_CLASSES = 5;
    localparam int VEC_W       = 4;
    localparam int SUM_W       = 16;
    localparam int CNT_W       = 12;
    localparam int IDX_W       = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WINDOW = 2'd1;
    localparam logic [1:0] ST_ACCUM  = 2'd2;
    localparam logic [1:0] ST_READ   = 2'd3;

    typedef logic [SUM_W-1:0] sum_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [VEC_W-1:0] vec_t;

    // Hamming distance class of a transition, 0..VEC_W.
    function automatic logic [IDX_W-1:0] popcount_vec(input vec_t v);
        logic [IDX_W-1:0] n;
        n = '0;
        for (int i = 0; i < VEC_W; i++) begin
            n = n + IDX_W'(v[i]);
        end
        return n;
    endfunction

    function automatic sum_t sum_sat_add(input sum_t a, input sum_t b);
        logic [SUM_W:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        return wide[SUM_W] ? '1 : wide[SUM_W-1:0];
    endfunction

    function automatic cnt_t cnt_sat_inc(input cnt_t a);
        return (a == '1) ? a : a + CNT_W'(1);
    endfunction

endpackage

// File: rtl/corr_toggle_det.sv
// Brings the asynchronous gate output into the clock domain and flags each
// change of the synchronized level for exactly one cycle.
module corr_toggle_det
    import corr_collector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic y_i,
    output logic toggle_o
);

    // sync_q[0], sync_q[1] form the synchronizer; sync_q[2] holds the previous level.
    logic [2:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], y_i};
        end
    end

    assign toggle_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/corr_collector.sv
// Counts gate-output toggles per experiment window and accumulates them into
// per-Hamming-distance classes, with a single-cycle readout port.
module corr_collector
    import corr_collector_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int TOG_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             done_i,
    input  logic [VEC_W-1:0] vec_from_i,
    input  logic [VEC_W-1:0] vec_to_i,
    input  logic             y_i,
    input  logic             clear_i,
    input  logic             rd_req_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [SUM_W-1:0] rd_sum_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic             busy_o,
    output logic             err_timeout_o,
    output logic             err_overlap_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [1:0]       state_q, state_d;
    vec_t             vec_from_q, vec_from_d;
    vec_t             vec_to_q, vec_to_d;
    logic [TOG_W-1:0] tog_q, tog_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    sum_t             sum_q [NUM_CLASSES];
    sum_t             sum_d [NUM_CLASSES];
    cnt_t             cnt_q [NUM_CLASSES];
    cnt_t             cnt_d [NUM_CLASSES];
    logic             rd_valid_q, rd_valid_d;
    sum_t             rd_sum_q, rd_sum_d;
    cnt_t             rd_cnt_q, rd_cnt_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_overlap_q, err_overlap_d;

    logic             toggle;
    logic [TOG_W-1:0] tog_sat;
    logic [IDX_W-1:0] acc_class;

    corr_toggle_det u_toggle_det (
        .clk      (clk),
        .rst      (rst),
        .y_i      (y_i),
        .toggle_o (toggle)
    );

    assign tog_sat   = (tog_q == '1) ? tog_q : tog_q + TOG_W'(1);
    assign acc_class = popcount_vec(vec_from_q ^ vec_to_q);

    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        vec_from_d    = vec_from_q;
        vec_to_d      = vec_to_q;
        tog_d         = tog_q;
        timer_d       = timer_q;
        sum_d         = sum_q;
        cnt_d         = cnt_q;
        rd_valid_d    = 1'b0;
        rd_sum_d      = '0;
        rd_cnt_d      = '0;
        err_timeout_d = 1'b0;
        err_overlap_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    vec_from_d = vec_from_i;
                    vec_to_d   = vec_to_i;
                    tog_d      = '0;
                    timer_d    = '0;
                    state_d    = ST_WINDOW;
                end else if (rd_req_i) begin
                    // Out-of-range indices match no class and read back as zero.
                    rd_valid_d = 1'b1;
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        if (rd_idx_i == IDX_W'(k)) begin
                            rd_sum_d = sum_q[k];
                            rd_cnt_d = cnt_q[k];
                        end
                    end
                    state_d = ST_READ;
                end else if (clear_i) begin
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        sum_d[k] = '0;
                        cnt_d[k] = '0;
                    end
                end
            end

            ST_WINDOW: begin
                if (toggle) begin
                    tog_d = tog_sat;
                end
                timer_d = timer_q + TMR_W'(1);
                if (done_i) begin
                    err_overlap_d = start_i;
                    state_d       = ST_ACCUM;
                end else if (start_i) begin
                    vec_from_d    = vec_from_i;
                    vec_to_d      = vec_to_i;
                    tog_d         = '0;
                    timer_d       = '0;
                    err_overlap_d = 1'b1;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end

            ST_ACCUM: begin
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    if (acc_class == IDX_W'(k)) begin
                        sum_d[k] = sum_sat_add(sum_q[k], SUM_W'(tog_q));
                        cnt_d[k] = cnt_sat_inc(cnt_q[k]);
                    end
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the class table is only ten small registers, so it is reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            vec_from_q    <= '0;
            vec_to_q      <= '0;
            tog_q         <= '0;
            timer_q       <= '0;
            rd_valid_q    <= 1'b0;
            rd_sum_q      <= '0;
            rd_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
            err_overlap_q <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                sum_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            vec_from_q    <= vec_from_d;
            vec_to_q      <= vec_to_d;
            tog_q         <= tog_d;
            timer_q       <= timer_d;
            rd_valid_q    <= rd_valid_d;
            rd_sum_q      <= rd_sum_d;
            rd_cnt_q      <= rd_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_overlap_q <= err_overlap_d;
            sum_q         <= sum_d;
            cnt_q         <= cnt_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign rd_valid_o    = rd_valid_q;
    assign rd_sum_o      = rd_sum_q;
    assign rd_cnt_o      = rd_cnt_q;
    assign err_timeout_o = err_timeout_q;
    assign err_overlap_o = err_overlap_q;

endmodule
